ir_intf_multi: RTL

Parametrised successor to the three-channel IR sensor interface in the KnightsTour robot. It drives the shared IR emitter enable with a fixed duty window and samples NUM_CH active-low IR receivers once per window. Each channel is debounced across consecutive windows and can be masked per channel, and the block emits one-cycle rise/fall event pulses. It sits between the IR pins and cmd_proc/inert_intf; with NUM_CH=3 and FILT_N=1 it replaces the existing IR interface.

---
 rtl/ir_intf_multi.sv | 134 +++++++++++++
 1 files changed

// File: rtl/ir_intf_multi.sv
// Multi-channel IR sensor front end: drives the shared emitter with a fixed duty window,
// samples each receiver once per window, debounces across windows and flags rise/fall events.
module ir_intf_multi #(
    parameter int NUM_CH     = 3,
    parameter int FAST_SIM   = 0,
    parameter int PERIOD_CYC = 500000,
    parameter int EN_CYC     = 25000,
    parameter int FILT_N     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] ir_n,
    input  logic [NUM_CH-1:0] ch_mask,
    output logic              IR_en,
    output logic [NUM_CH-1:0] ir,
    output logic [NUM_CH-1:0] ir_rise,
    output logic [NUM_CH-1:0] ir_fall,
    output logic              smpl_vld
);

    // state | meaning
    // ON    | emitter on, counter 0..E-1
    // SMPL  | single sample cycle at count E
    // OFF   | emitter off, counter E+1..P-1

    localparam int P  = (FAST_SIM != 0) ? 4096 : PERIOD_CYC;
    localparam int E  = (FAST_SIM != 0) ? 256  : EN_CYC;
    localparam int CW = $clog2(P);
    localparam int FW = 4;

    localparam logic [CW-1:0] CNT_LAST    = CW'(P - 1);
    localparam logic [CW-1:0] CNT_EN_LAST = CW'(E - 1);
    localparam logic [FW-1:0] FILT_LAST   = FW'(FILT_N - 1);

    typedef enum logic [1:0] {
        ST_ON   = 2'd0,
        ST_SMPL = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]             cnt;
    logic [NUM_CH-1:0]         sync1, sync2;
    logic [NUM_CH-1:0]         raw;
    logic [NUM_CH-1:0][FW-1:0] flt_cnt, flt_nxt;
    logic [NUM_CH-1:0]         ir_nxt, rise_nxt, fall_nxt;

    assign raw = ~sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Receivers idle high, so the synchroniser resets to the inactive level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= ir_n;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_ON;
        end else begin
            state <= state_nxt;
        end
    end

    // SMPL can land on the last count when E = P-1, so it must be able to wrap straight to ON.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_ON:   if (cnt == CNT_EN_LAST) state_nxt = ST_SMPL;
            ST_SMPL: state_nxt = (cnt == CNT_LAST) ? ST_ON : ST_OFF;
            ST_OFF:  if (cnt == CNT_LAST) state_nxt = ST_ON;
            default: state_nxt = ST_ON;
        endcase
    end

    always_comb begin
        ir_nxt   = ir;
        rise_nxt = '0;
        fall_nxt = '0;
        flt_nxt  = flt_cnt;
        if (state == ST_SMPL) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!ch_mask[i]) begin
                    ir_nxt[i]  = 1'b0;
                    flt_nxt[i] = '0;
                end else if (raw[i] == ir[i]) begin
                    flt_nxt[i] = '0;
                end else if (flt_cnt[i] == FILT_LAST) begin
                    ir_nxt[i]   = raw[i];
                    flt_nxt[i]  = '0;
                    rise_nxt[i] = raw[i];
                    fall_nxt[i] = ~raw[i];
                end else begin
                    flt_nxt[i] = flt_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Outputs are registered decodes of the current state, so IR_en spans counts 1..E.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            IR_en    <= 1'b0;
            smpl_vld <= 1'b0;
            ir       <= '0;
            ir_rise  <= '0;
            ir_fall  <= '0;
            flt_cnt  <= '0;
        end else begin
            IR_en    <= (state == ST_ON);
            smpl_vld <= (state == ST_SMPL);
            ir       <= ir_nxt;
            ir_rise  <= rise_nxt;
            ir_fall  <= fall_nxt;
            flt_cnt  <= flt_nxt;
        end
    end

endmodule
